attn_core_sequencer: RTL and testbench

- Instruction sequencer that drives the 19-bit `inst` bus of the single core.
- One `start` pulse runs a complete pass with no further host involvement:
  - write Q vectors into qmem;
  - write K vectors into kmem;
  - load K into the PE array;
  - execute over all Q vectors;
  - drain the output FIFO into pmem.
- Sits between the host/testbench and the core. It tells the host which vector to present on `mem_in` each cycle.

---
 rtl/attn_core_sequencer.sv | 158 +++++++++++++++
 tb/tb_attn_core_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/attn_core_sequencer.sv
// rtl/attn_core_sequencer.sv - instruction sequencer driving one attention core pass per start pulse
module attn_core_sequencer #(
  parameter int col         = 8,
  parameter int total_cycle = 8,
  parameter int load_gap    = 8,
  parameter int addr_w      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [18:0] inst,
  output logic        vec_req,
  output logic        vec_kind,
  output logic [3:0]  vec_idx,
  output logic        busy,
  output logic        done
);

  localparam int CW = 5;

  typedef enum logic [2:0] {
    IDLE, WR_Q, WR_K, LD_K, GAP, EXEC, DRAIN, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   j_q, j_d;
  logic [18:0]     inst_q, inst_d;
  logic            vec_req_q, vec_req_d;
  logic            vec_kind_q, vec_kind_d;
  logic [3:0]      vec_idx_q, vec_idx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rd_d;
  logic            wr_d;
  logic [addr_w-1:0] wr_row;

  // A read issued in the current cycle (inst_q[16]) becomes the pmem write of the next cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = WR_Q;
      end
      WR_Q: if (cnt_q == CW'(total_cycle - 1)) begin
        state_d = WR_K;
        cnt_d   = '0;
      end
      WR_K: if (cnt_q == CW'(col - 1)) begin
        state_d = LD_K;
        cnt_d   = '0;
      end
      LD_K: if (cnt_q == CW'(col - 1)) begin
        state_d = (load_gap == 0) ? EXEC : GAP;
        cnt_d   = '0;
      end
      GAP: if (cnt_q == CW'(load_gap - 1)) begin
        state_d = EXEC;
        cnt_d   = '0;
      end
      EXEC: if (cnt_q == CW'(total_cycle - 1)) begin
        state_d = DRAIN;
        cnt_d   = '0;
      end
      DRAIN: begin
        cnt_d = '0;
        if (inst_q[0] && !inst_q[16] && (j_q == CW'(total_cycle))) state_d = DONE;
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rd_d       = (state_d == DRAIN) && (j_q < CW'(total_cycle)) && ofifo_valid;
    wr_d       = (state_q == DRAIN) && inst_q[16];
    j_d        = (state_d == DRAIN) ? (j_q + CW'(rd_d)) : '0;
    wr_row     = addr_w'(j_q - CW'(1));
    inst_d     = '0;
    vec_req_d  = 1'b0;
    vec_kind_d = 1'b0;
    vec_idx_d  = '0;
    busy_d     = (state_d != IDLE) && (state_d != DONE);
    done_d     = (state_d == DONE);
    case (state_d)
      WR_Q: begin
        inst_d[2]             = 1'b1;
        inst_d[12 +: addr_w]  = cnt_d[addr_w-1:0];
        vec_req_d             = 1'b1;
        vec_idx_d             = cnt_d[3:0];
      end
      WR_K: begin
        inst_d[4]             = 1'b1;
        inst_d[12 +: addr_w]  = cnt_d[addr_w-1:0];
        vec_req_d             = 1'b1;
        vec_kind_d            = 1'b1;
        vec_idx_d             = cnt_d[3:0];
      end
      LD_K: begin
        inst_d[5]             = 1'b1;
        inst_d[6]             = 1'b1;
        inst_d[12 +: addr_w]  = cnt_d[addr_w-1:0];
      end
      EXEC: begin
        inst_d[3]             = 1'b1;
        inst_d[7]             = 1'b1;
        inst_d[12 +: addr_w]  = cnt_d[addr_w-1:0];
      end
      DRAIN: begin
        inst_d[16]            = rd_d;
        inst_d[0]             = wr_d;
        if (wr_d) inst_d[8 +: addr_w] = wr_row;
      end
      default: inst_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      j_q        <= '0;
      inst_q     <= '0;
      vec_req_q  <= 1'b0;
      vec_kind_q <= 1'b0;
      vec_idx_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      j_q        <= j_d;
      inst_q     <= inst_d;
      vec_req_q  <= vec_req_d;
      vec_kind_q <= vec_kind_d;
      vec_idx_q  <= vec_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign inst     = inst_q;
  assign vec_req  = vec_req_q;
  assign vec_kind = vec_kind_q;
  assign vec_idx  = vec_idx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_attn_core_sequencer.sv
// tb/tb_attn_core_sequencer.sv - self-checking bench for attn_core_sequencer
module tb_attn_core_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic        valid_a, valid_b;
  logic [18:0] inst_a, inst_b;
  logic        req_a, req_b, kind_a, kind_b, busy_a, busy_b, done_a, done_b;
  logic [3:0]  idx_a, idx_b;

  int vectors = 0;
  int miscompares = 0;

  logic [26:0] exp_tr [0:511];
  logic        vin [0:511];
  logic        extra_start [0:511];
  int          exp_len;

  always #5 clk = ~clk;

  attn_core_sequencer dut_a (
    .clk(clk), .reset(reset), .start(start_a), .ofifo_valid(valid_a),
    .inst(inst_a), .vec_req(req_a), .vec_kind(kind_a), .vec_idx(idx_a),
    .busy(busy_a), .done(done_a)
  );

  attn_core_sequencer #(.col(8), .total_cycle(1), .load_gap(0), .addr_w(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .ofifo_valid(valid_b),
    .inst(inst_b), .vec_req(req_b), .vec_kind(kind_b), .vec_idx(idx_b),
    .busy(busy_b), .done(done_b)
  );

  function automatic logic [26:0] pack(input logic [18:0] i, input logic rq, input logic kd,
                                       input logic [3:0] ix, input logic b, input logic d);
    return {i, rq, kd, ix, b, d};
  endfunction

  function automatic logic [26:0] observe(input bit sel);
    if (sel) return {inst_b, req_b, kind_b, idx_b, busy_b, done_b};
    return {inst_a, req_a, kind_a, idx_a, busy_a, done_a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stim(input bit rand_valid);
    for (int c = 0; c < 512; c++) begin
      vin[c]         = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      extra_start[c] = 1'b0;
      if (c > 300) vin[c] = 1'b1;
    end
  endtask

  // Expected per-cycle trace built segment by segment; cycle c holds what the DUT shows after edge c-1.
  task automatic build_model(input int tc, input int colp, input int gap);
    int c, j, pend;
    logic [18:0] w;
    bit fin;
    c = 1;
    for (int i = 0; i < tc; i++) begin
      w = '0; w[2] = 1'b1; w[15:12] = 4'(i);
      exp_tr[c++] = pack(w, 1'b1, 1'b0, 4'(i), 1'b1, 1'b0);
    end
    for (int i = 0; i < colp; i++) begin
      w = '0; w[4] = 1'b1; w[15:12] = 4'(i);
      exp_tr[c++] = pack(w, 1'b1, 1'b1, 4'(i), 1'b1, 1'b0);
    end
    for (int i = 0; i < colp; i++) begin
      w = '0; w[5] = 1'b1; w[6] = 1'b1; w[15:12] = 4'(i);
      exp_tr[c++] = pack(w, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    end
    for (int i = 0; i < gap; i++) exp_tr[c++] = pack(19'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < tc; i++) begin
      w = '0; w[3] = 1'b1; w[7] = 1'b1; w[15:12] = 4'(i);
      exp_tr[c++] = pack(w, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    end
    j = 0; pend = -1; fin = 1'b0;
    while (!fin && c < 505) begin
      w = '0;
      if (pend >= 0) begin
        w[0] = 1'b1; w[11:8] = 4'(pend);
        if (pend == tc - 1) fin = 1'b1;
      end
      if (j < tc && vin[c]) begin
        w[16] = 1'b1; pend = j; j++;
      end else begin
        pend = -1;
      end
      exp_tr[c++] = pack(w, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    end
    exp_tr[c++] = pack(19'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    exp_tr[c]   = '0;
    exp_tr[c+1] = '0;
    exp_len     = c + 1;
  endtask

  // Runs a pass on the selected DUT, checking cycles 1..last (last=0 means the whole trace).
  task automatic run_check(input bit sel, input string tag, input int last);
    int n, dones, rsv;
    logic [26:0] obs;
    n = (last == 0) ? exp_len : last;
    dones = 0; rsv = 0;
    if (sel) begin start_b = 1'b1; valid_b = vin[1]; end
    else     begin start_a = 1'b1; valid_a = vin[1]; end
    for (int c = 1; c <= n; c++) begin
      step();
      if (sel) begin start_b = extra_start[c]; valid_b = vin[c+1]; end
      else     begin start_a = extra_start[c]; valid_a = vin[c+1]; end
      obs = observe(sel);
      if (obs[26:25] != 2'b00 || obs[9] != 1'b0) rsv++;
      if (obs[0]) dones++;
      vectors++;
      assert (obs === exp_tr[c]) else begin
        miscompares++;
        $error("FAIL %s cycle %0d: observed %h expected %h", tag, c, obs, exp_tr[c]);
      end
    end
    if (sel) start_b = 1'b0; else start_a = 1'b0;
    if (last == 0) begin
      vectors++;
      assert (dones === 1) else begin
        miscompares++;
        $error("FAIL %s_done_count: observed %0d expected 1", tag, dones);
      end
      vectors++;
      assert (rsv === 0) else begin
        miscompares++;
        $error("FAIL %s_reserved: observed %0d bad cycles expected 0", tag, rsv);
      end
    end
  endtask

  task automatic check_idle(input bit sel, input string tag);
    logic [26:0] obs;
    obs = observe(sel);
    vectors++;
    assert (obs === 27'd0) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, 27'd0);
    end
  endtask

  initial begin
    reset = 1'b0; start_a = 1'b0; start_b = 1'b0; valid_a = 1'b1; valid_b = 1'b1;
    step();
    step();
    check_idle(1'b0, "reset_a");
    check_idle(1'b1, "reset_b");
    reset = 1'b1;
    step();

    clear_stim(1'b0);
    build_model(8, 8, 8);
    run_check(1'b0, "nominal", 0);

    clear_stim(1'b0);
    for (int c = 41; c <= 45; c++) vin[c] = 1'b0;
    build_model(8, 8, 8);
    run_check(1'b0, "stall", 0);

    clear_stim(1'b0);
    extra_start[5]  = 1'b1;
    extra_start[50] = 1'b1;
    build_model(8, 8, 8);
    run_check(1'b0, "start_busy", 0);

    clear_stim(1'b0);
    build_model(8, 8, 8);
    run_check(1'b0, "pre_reset", 20);
    reset = 1'b0;
    step();
    check_idle(1'b0, "mid_reset");
    reset = 1'b1;
    step();
    check_idle(1'b0, "post_reset_idle");
    run_check(1'b0, "rerun", 0);

    for (int r = 0; r < 3; r++) begin
      clear_stim(1'b1);
      build_model(8, 8, 8);
      run_check(1'b0, "random_a", 0);
    end

    clear_stim(1'b0);
    build_model(1, 8, 0);
    run_check(1'b1, "corner", 0);

    for (int r = 0; r < 2; r++) begin
      clear_stim(1'b1);
      build_model(1, 8, 0);
      run_check(1'b1, "random_b", 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
